// File: rtl/serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_shifter
// Description : Iterative SLL/SRL/SRA execution unit with start/busy/done
//               handshake. Define SERIAL_SHIFTER_NIBBLE_STEP_EN to retire up
//               to four bit positions per SHIFT cycle instead of one.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [2:0]      funct3,
    input  logic            arith,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_f3_sll = 3'b001;
    localparam logic [2:0] c_f3_sr  = 3'b101;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  count_q, count_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;

    logic [SHW-1:0]  w_shamt;
    logic [SHW-1:0]  w_step;
    logic            w_legal;
    logic            w_unused;

    // Only the low SHW bits of either shift source carry the amount.
    assign w_unused = ^{rd2[XLEN-1:SHW], imm[XLEN-1:SHW]};
    assign w_shamt  = alu_src ? imm[SHW-1:0] : rd2[SHW-1:0];
    assign w_legal  = (funct3 == c_f3_sll) || (funct3 == c_f3_sr);

`ifdef SERIAL_SHIFTER_NIBBLE_STEP_EN
    localparam logic [SHW-1:0] c_nibble = SHW'(4);
    assign w_step = (count_q > c_nibble) ? c_nibble : count_q;
`else
    assign w_step = SHW'(1);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        left_d   = left_q;
        arith_d  = arith_q;
        case (state_q)
            S_SHIFT: begin
                if (left_q) begin
                    result_d = result_q << w_step;
                end else if (arith_q) begin
                    result_d = $unsigned($signed(result_q) >>> w_step);
                end else begin
                    result_d = result_q >> w_step;
                end
                count_d = count_q - w_step;
                if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE still shows its pulse this cycle.
                state_d = S_IDLE;
                if (start) begin
                    result_d = operand;
                    count_d  = w_legal ? w_shamt : '0;
                    left_d   = (funct3 == c_f3_sll);
                    arith_d  = arith;
                    state_d  = (count_d != '0) ? S_SHIFT : S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            count_q  <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Multi-cycle shift execution unit in the EX stage of the rv32i core.
- Sits directly downstream of the shift-immediate conditioning stage and consumes its operand outputs: rs1 value, conditioned rd2, conditioned immediate and alu_src.
- Performs SLL/SLLI, SRL/SRLI and SRA/SRAI iteratively, one bit position per cycle, behind a start/busy/done handshake. This replaces a 32-bit barrel shifter to save area.

Parameters:
- XLEN, 32, operand/result width
- SHW, 5, shift-amount width (log2 XLEN)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- operand  input  XLEN  value to shift (rs1)
- rd2  input  XLEN  conditioned rs2 value; bits [SHW-1:0] are the register shift amount
- imm  input  XLEN  conditioned immediate; bits [SHW-1:0] are the immediate shift amount
- alu_src  input  1  1 = shift amount from imm, 0 = shift amount from rd2
- funct3  input  3  001 = left shift, 101 = right shift
- arith  input  1  funct7[5]; with funct3=101, 1 = SRA, 0 = SRL
- result  output  XLEN  shifted value; held until the next accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, high in the DONE state

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, internal count=0, busy=0, done=0. Reset mid-shift aborts the operation; no done pulse is issued.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly 1 cycle.
- Accept: start=1 at a rising edge while in IDLE or DONE.
  - Capture result<=operand.
  - Capture N = alu_src ? imm[4:0] : rd2[4:0]; upper bits are ignored.
  - Capture the mode.
  - Next state: SHIFT if N>0, else DONE.
- start while in SHIFT is ignored: not queued, no state change.
- start during DONE is accepted. The done pulse still appears for the old operation in that cycle, and the new operation begins at the same edge.
- Each SHIFT cycle shifts result by 1 and decrements count.
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with result[XLEN-1].
  - When count reaches 0, the next state is DONE.
- Latency: start high in cycle 0 → done high in cycle N+1. result is final and stable from that cycle until the next accept.
- After DONE with no start → IDLE.
- funct3 other than 001/101: the operation is treated as a pass-through. result=operand, forced N=0, done in cycle 1.
- arith is ignored for funct3=001.
- Inputs are only sampled at accept; changes during SHIFT have no effect.

Optional Feature:
- Macro SERIAL_SHIFTER_NIBBLE_STEP_EN.
- When defined: each SHIFT cycle shifts by min(4, count) and decrements count by the same amount. Latency becomes done in cycle ceil(N/4)+1; N=0 still gives done in cycle 1.
- When not defined: 1 bit per cycle as specified above.
- Results are identical in both configurations.

Test Plan:
- Long SLL: operand=0x00000001, rd2=0x0000001F, alu_src=0, funct3=001, start pulse → busy for cycles 1-31, done in cycle 32 (nibble: cycle 9), result=0x80000000.
- SRAI: operand=0x80000000, imm=0x00000404 (only low 5 bits used → 4), alu_src=1, funct3=101, arith=1 → done in cycle 5 (nibble: cycle 2), result=0xF8000000.
- SRL with upper bits ignored: operand=0x80000000, rd2=0x00000023 (→3), alu_src=0, funct3=101, arith=0 → done in cycle 4, result=0x10000000.
- Zero shift and illegal funct3:
  - N=0, operand=0xDEADBEEF → done in cycle 1, result=0xDEADBEEF, busy never high.
  - funct3=000, N=7 → same behaviour.
- Back-to-back operation:
  - Second start during SHIFT is ignored; result matches the first operation only.
  - Start held high through the DONE cycle → new operation accepted at that edge; busy rises the next cycle.
- Reset mid-operation: assert rst asynchronously in cycle 10 of a 31-bit shift → busy, done and result drop to 0 immediately; no done pulse follows; the next start behaves normally.
